// File: rtl/writeback_stage.sv
// writeback_stage: RV32I MEM/WB stage with an internal word-addressed data RAM.
// Performs the data-memory access for loads and stores, holds the MEM/WB
// pipeline register, drives the writeback result and flags illegal accesses.
// Optional feature macro: WB_PERF_CNT_EN (saturating accepted load/store counters).
module writeback_stage #(
    parameter int DPW        = 32,
    parameter int ADW        = 5,
    parameter int DMEM_DEPTH = 256
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           regwriteM,
    input  logic           resultsrcM,
    input  logic           memwriteM,
    input  logic [DPW-1:0] aluresultM,
    input  logic [DPW-1:0] Rd2M,
    input  logic [ADW-1:0] RdM,
    output logic           regwriteW,
    output logic [ADW-1:0] RdW,
    output logic [DPW-1:0] resultW,
    output logic           mem_err,
    output logic [31:0]    load_cnt,
    output logic [31:0]    store_cnt
);

    localparam int AW = $clog2(DMEM_DEPTH);

    // Data RAM contents are deliberately not reset
    logic [DPW-1:0] ram [DMEM_DEPTH];

    logic [AW-1:0]  word_index;
    logic           misaligned;
    logic           out_of_range;
    logic           illegal;
    logic           access;
    logic           store_ok;
    logic           load_ok;

    logic           resultsrcW;
    logic [DPW-1:0] aluresultW;
    logic [DPW-1:0] readdataW;

    // Byte address decode: word index plus the two kinds of illegal access
    assign word_index   = aluresultM[AW+1:2];
    assign misaligned   = |aluresultM[1:0];
    assign out_of_range = |aluresultM[DPW-1:AW+2];
    assign illegal      = misaligned | out_of_range;
    assign access       = memwriteM | resultsrcM;
    assign store_ok     = memwriteM & ~illegal;
    assign load_ok      = resultsrcM & ~illegal;

    // Store port: illegal stores are dropped so RAM is never corrupted
    always_ff @(posedge clk) begin
        if (store_ok) begin
            ram[word_index] <= Rd2M;
        end
    end

    // MEM/WB register and synchronous read; a coincident legal store forwards its data
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            regwriteW  <= 1'b0;
            RdW        <= '0;
            resultsrcW <= 1'b0;
            aluresultW <= '0;
            readdataW  <= '0;
        end else begin
            regwriteW  <= regwriteM;
            RdW        <= RdM;
            resultsrcW <= resultsrcM;
            aluresultW <= aluresultM;
            if (load_ok) begin
                readdataW <= store_ok ? Rd2M : ram[word_index];
            end else begin
                readdataW <= '0;
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem_err <= 1'b0;
        end else if (access && illegal) begin
            mem_err <= 1'b1;
        end
    end

    assign resultW = resultsrcW ? readdataW : aluresultW;

`ifdef WB_PERF_CNT_EN
    // Saturating counters of accepted (legal) loads and stores
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (load_ok && (load_cnt != 32'hFFFF_FFFF)) begin
                load_cnt <= load_cnt + 32'd1;
            end
            if (store_ok && (store_cnt != 32'hFFFF_FFFF)) begin
                store_cnt <= store_cnt + 32'd1;
            end
        end
    end
`else
    assign load_cnt  = '0;
    assign store_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard bench for writeback_stage. A driver issues
// directed and random M-stage bundles and pushes the expected W-stage view
// computed from an abstract memory model; a monitor pops and compares.
module tb_writeback_stage;

    localparam int DEPTH = 256;

    logic        clk;
    logic        arst_n;
    logic        regwriteM;
    logic        resultsrcM;
    logic        memwriteM;
    logic [31:0] aluresultM;
    logic [31:0] Rd2M;
    logic [4:0]  RdM;
    logic        regwriteW;
    logic [4:0]  RdW;
    logic [31:0] resultW;
    logic        mem_err;
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] result;
        bit          check_result;
        logic        err;
        logic [31:0] lc;
        logic [31:0] sc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ram_model [int];
    logic        err_model;
    logic [31:0] lc_model;
    logic [31:0] sc_model;
    int          checks;
    int          errors;

    writeback_stage #(.DPW(32), .ADW(5), .DMEM_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .memwriteM  (memwriteM),
        .aluresultM (aluresultM),
        .Rd2M       (Rd2M),
        .RdM        (RdM),
        .regwriteW  (regwriteW),
        .RdW        (RdW),
        .resultW    (resultW),
        .mem_err    (mem_err),
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_output(input exp_t e);
        compare("regwriteW", {31'd0, regwriteW}, {31'd0, e.rw});
        compare("RdW", {27'd0, RdW}, {27'd0, e.rd});
        if (e.check_result) compare("resultW", resultW, e.result);
        compare("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        compare("load_cnt", load_cnt, e.lc);
        compare("store_cnt", store_cnt, e.sc);
    endtask

    // Drive one M-stage bundle at a falling edge and queue what W must show after the next rise
    task automatic apply_stimulus(input logic rw, input logic rs, input logic mw,
                                  input logic [31:0] alu, input logic [31:0] d, input logic [4:0] rd);
        exp_t        e;
        bit          legal;
        int          idx;
        logic [31:0] rdata;
        bit          known;
        @(negedge clk);
        regwriteM  = rw;
        resultsrcM = rs;
        memwriteM  = mw;
        aluresultM = alu;
        Rd2M       = d;
        RdM        = rd;
        legal = (alu % 4 == 0) && (alu < 4 * DEPTH);
        idx   = int'(alu / 4);
        known = 1'b1;
        rdata = 32'd0;
        if (rs && legal) begin
            if (mw) rdata = d;
            else if (ram_model.exists(idx)) rdata = ram_model[idx];
            else known = 1'b0;
        end
        if (mw && legal) ram_model[idx] = d;
        if ((rs || mw) && !legal) err_model = 1'b1;
`ifdef WB_PERF_CNT_EN
        if (rs && legal) lc_model++;
        if (mw && legal) sc_model++;
`endif
        e.rw           = rw;
        e.rd           = rd;
        e.result       = rs ? rdata : alu;
        e.check_result = rs ? known : 1'b1;
        e.err          = err_model;
        e.lc           = lc_model;
        e.sc           = sc_model;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        compare({tag, " regwriteW"}, {31'd0, regwriteW}, 32'd0);
        compare({tag, " RdW"}, {27'd0, RdW}, 32'd0);
        compare({tag, " resultW"}, resultW, 32'd0);
        compare({tag, " mem_err"}, {31'd0, mem_err}, 32'd0);
        compare({tag, " load_cnt"}, load_cnt, 32'd0);
        compare({tag, " store_cnt"}, store_cnt, 32'd0);
    endtask

    // Monitor: pop and compare one expectation per rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (arst_n && exp_q.size() > 0) begin
                check_output(exp_q.pop_front());
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic
    initial begin
        int sel;
        logic [31:0] addr;
        checks = 0;
        errors = 0;
        err_model = 1'b0;
        lc_model = 32'd0;
        sc_model = 32'd0;
        arst_n = 1'b0;
        regwriteM = 1'b0;
        resultsrcM = 1'b0;
        memwriteM = 1'b0;
        aluresultM = 32'd0;
        Rd2M = 32'd0;
        RdM = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        arst_n = 1'b1;

        $display("[TB] store/load and ALU pass-through");
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7);

        $display("[TB] misaligned store and sticky error");
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h13, 32'hAAAA5555, 5'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd6);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        $display("[TB] out-of-range load and write-first");
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd9);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h20, 32'h0F0F0F0F, 5'd10);

        $display("[TB] asynchronous reset mid-stream");
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd11);
        @(posedge clk);
        #4;
        compare("pre-reset regwriteW", {31'd0, regwriteW}, 32'd1);
        compare("pre-reset resultW", resultW, 32'hDEADBEEF);
        arst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        err_model = 1'b0;
        lc_model = 32'd0;
        sc_model = 32'd0;
        regwriteM = 1'b0;
        resultsrcM = 1'b0;
        memwriteM = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd12);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd13);

        $display("[TB] counter scenario");
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h30, 32'h11112222, 5'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 5'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h34, 32'h33334444, 5'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h32, 32'h0, 5'd2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

        $display("[TB] randomized traffic");
        for (int w = 0; w < 16; w++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 32'(w * 4), $urandom, 5'd0);
        end
        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 7));
            if (sel < 6)       addr = 32'($urandom_range(0, 15) * 4);
            else if (sel == 6) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else               addr = 32'h400 + 32'($urandom_range(0, 1023) * 4);
            apply_stimulus(1'($urandom), 1'($urandom), 1'($urandom), addr, $urandom, 5'($urandom));
        end

        // Drain the scoreboard with a bounded wait
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
